// File: rtl/ddr_avalon_responder.sv
// Avalon-MM burst slave backed by on-chip RAM; stands in for the DDR controller
// behind the burst-coalesced load/store bridges so they can be simulated alone.
module ddr_avalon_responder #(
  parameter int AWIDTH           = 28,
  parameter int MWIDTH           = 256,
  parameter int BURSTCOUNT_WIDTH = 5,
  parameter int DEPTH_WORDS      = 1024,
  parameter int READ_LATENCY     = 4
) (
  input  logic                        clock,
  input  logic                        resetn,
  input  logic                        avs_enable,
  input  logic [AWIDTH-1:0]           avs_address,
  input  logic                        avs_read,
  input  logic                        avs_write,
  input  logic [BURSTCOUNT_WIDTH-1:0] avs_burstcount,
  input  logic [MWIDTH-1:0]           avs_writedata,
  input  logic [MWIDTH/8-1:0]         avs_byteenable,
  output logic                        avs_waitrequest,
  output logic [MWIDTH-1:0]           avs_readdata,
  output logic                        avs_readdatavalid,
  output logic                        avs_writeack,
  output logic                        o_err
);

  localparam int NBYTES    = MWIDTH / 8;
  localparam int LANE_BITS = $clog2(NBYTES);
  localparam int WA        = $clog2(DEPTH_WORDS);

  typedef logic [WA-1:0]               word_t;
  typedef logic [BURSTCOUNT_WIDTH-1:0] count_t;
  typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST} state_t;

  state_t state, state_next;
  word_t  addr_q, addr_next;
  count_t remain_q, remain_next;
  logic   writeack_next;
  logic   err_set;
  logic   wr_en;
  word_t  wr_addr;
  logic   rd_issue;
  word_t  rd_addr;
  word_t  cmd_word;
  count_t cmd_count;
  logic   addr_unused;

  logic [MWIDTH-1:0]       mem [DEPTH_WORDS];
  logic [READ_LATENCY-1:0] pipe_valid;
  logic [MWIDTH-1:0]       pipe_data [READ_LATENCY];

  // Lane bits and bits above the RAM depth only select bytes or alias words.
  assign cmd_word    = avs_address[LANE_BITS +: WA];
  assign addr_unused = ^{avs_address[LANE_BITS-1:0], avs_address[AWIDTH-1:LANE_BITS+WA]};
  assign cmd_count   = (avs_burstcount == '0) ? count_t'(1) : avs_burstcount;

  always_comb begin
    state_next      = state;
    addr_next       = addr_q;
    remain_next     = remain_q;
    avs_waitrequest = 1'b1;
    writeack_next   = 1'b0;
    err_set         = 1'b0;
    wr_en           = 1'b0;
    wr_addr         = addr_q;
    rd_issue        = 1'b0;
    rd_addr         = addr_q;
    if (resetn) begin
      unique case (state)
        IDLE: begin
          avs_waitrequest = ~avs_enable;
          if (avs_enable && (avs_write || avs_read)) begin
            addr_next   = cmd_word + word_t'(1);
            remain_next = cmd_count - count_t'(1);
            if ((avs_burstcount == '0) || (avs_write && avs_read)) begin
              err_set = 1'b1;
            end
            // A write wins over a simultaneous read.
            if (avs_write) begin
              wr_en   = 1'b1;
              wr_addr = cmd_word;
              if (cmd_count == count_t'(1)) begin
                writeack_next = 1'b1;
              end else begin
                state_next = WR_BURST;
              end
            end else begin
              rd_issue = 1'b1;
              rd_addr  = cmd_word;
              if (cmd_count != count_t'(1)) begin
                state_next = RD_BURST;
              end
            end
          end
        end
        RD_BURST: begin
          rd_issue    = 1'b1;
          rd_addr     = addr_q;
          addr_next   = addr_q + word_t'(1);
          remain_next = remain_q - count_t'(1);
          if (remain_q == count_t'(1)) begin
            state_next = IDLE;
          end
        end
        WR_BURST: begin
          avs_waitrequest = 1'b0;
          err_set         = avs_read;
          if (avs_write) begin
            wr_en       = 1'b1;
            wr_addr     = addr_q;
            addr_next   = addr_q + word_t'(1);
            remain_next = remain_q - count_t'(1);
            if (remain_q == count_t'(1)) begin
              state_next    = IDLE;
              writeack_next = 1'b1;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state        <= IDLE;
      addr_q       <= '0;
      remain_q     <= '0;
      avs_writeack <= 1'b0;
      o_err        <= 1'b0;
    end else begin
      state        <= state_next;
      addr_q       <= addr_next;
      remain_q     <= remain_next;
      avs_writeack <= writeack_next;
      if (err_set) begin
        o_err <= 1'b1;
      end
    end
  end

  // RAM contents survive reset, so this block has none.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (avs_byteenable[b]) begin
          mem[wr_addr][b*8 +: 8] <= avs_writedata[b*8 +: 8];
        end
      end
    end
  end

  // Data stages only advance behind a valid beat so the output holds its last value.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      pipe_valid <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        pipe_data[i] <= '0;
      end
    end else begin
      pipe_valid[0] <= rd_issue;
      if (rd_issue) begin
        pipe_data[0] <= mem[rd_addr];
      end
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        if (pipe_valid[i-1]) begin
          pipe_data[i] <= pipe_data[i-1];
        end
      end
    end
  end

  assign avs_readdatavalid = pipe_valid[READ_LATENCY-1];
  assign avs_readdata      = pipe_data[READ_LATENCY-1];

endmodule

// File: tb/tb_ddr_avalon_responder.sv
// Self-checking bench for ddr_avalon_responder: random bursts against a
// word-array memory model with expected beat timing derived from accept cycles.
module tb_ddr_avalon_responder;

  localparam int AWIDTH = 28;
  localparam int MWIDTH = 256;
  localparam int BCW    = 5;
  localparam int DEPTH  = 1024;
  localparam int RL     = 4;
  localparam int NB     = MWIDTH / 8;

  logic              clock          = 1'b0;
  logic              resetn         = 1'b0;
  logic              avs_enable     = 1'b1;
  logic [AWIDTH-1:0] avs_address    = '0;
  logic              avs_read       = 1'b0;
  logic              avs_write      = 1'b0;
  logic [BCW-1:0]    avs_burstcount = '0;
  logic [MWIDTH-1:0] avs_writedata  = '0;
  logic [NB-1:0]     avs_byteenable = '0;
  logic              avs_waitrequest;
  logic [MWIDTH-1:0] avs_readdata;
  logic              avs_readdatavalid;
  logic              avs_writeack;
  logic              o_err;

  ddr_avalon_responder #(
    .AWIDTH(AWIDTH), .MWIDTH(MWIDTH), .BURSTCOUNT_WIDTH(BCW),
    .DEPTH_WORDS(DEPTH), .READ_LATENCY(RL)
  ) dut (
    .clock(clock), .resetn(resetn), .avs_enable(avs_enable),
    .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
    .avs_burstcount(avs_burstcount), .avs_writedata(avs_writedata),
    .avs_byteenable(avs_byteenable), .avs_waitrequest(avs_waitrequest),
    .avs_readdata(avs_readdata), .avs_readdatavalid(avs_readdatavalid),
    .avs_writeack(avs_writeack), .o_err(o_err)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int                c;
    logic [MWIDTH-1:0] d;
  } beat_t;

  beat_t got_q[$];
  beat_t exp_q[$];
  int    ack_q[$];
  int    exp_ack[$];
  beat_t mon_b;

  // Observed read beats and write acks, tagged with the cycle they appear in.
  always @(negedge clock) begin
    if (avs_readdatavalid === 1'b1) begin
      mon_b.c = cyc;
      mon_b.d = avs_readdata;
      got_q.push_back(mon_b);
    end
    if (avs_writeack === 1'b1) ack_q.push_back(cyc);
  end

  logic [MWIDTH-1:0] model_mem [DEPTH];
  logic [MWIDTH-1:0] wdata [16];
  logic [NB-1:0]     wbe [16];
  int passed = 0;
  int total  = 0;

  function automatic logic [MWIDTH-1:0] rand_word();
    logic [MWIDTH-1:0] r;
    for (int i = 0; i < MWIDTH/32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Random lane offset and random aliasing bits above the RAM depth.
  function automatic logic [AWIDTH-1:0] byte_addr(input int word);
    return AWIDTH'((word + DEPTH * $urandom_range(0, 7)) * NB + $urandom_range(0, NB-1));
  endfunction

  function automatic void model_write(input int word, input logic [MWIDTH-1:0] d, input logic [NB-1:0] be);
    for (int b = 0; b < NB; b++)
      if (be[b]) model_mem[word % DEPTH][b*8 +: 8] = d[b*8 +: 8];
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_queues();
    got_q.delete();
    exp_q.delete();
    ack_q.delete();
    exp_ack.delete();
  endtask

  task automatic do_reset();
    avs_read  = 1'b0;
    avs_write = 1'b0;
    resetn    = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    tick();
    clear_queues();
  endtask

  task automatic wait_accept(output int t);
    int n;
    n = 0;
    #1;
    while (avs_waitrequest !== 1'b0 && n < 64) begin
      @(posedge clock);
      #2;
      n++;
    end
    t = cyc;
    total++;
    if (n >= 64) $display("[TB] FAIL accept_timeout: waitrequest=%b required 0", avs_waitrequest);
    else passed++;
    @(posedge clock);
    #1;
  endtask

  task automatic rd_burst(input int word, input int n, output int t);
    int    nn;
    beat_t b;
    nn             = (n == 0) ? 1 : n;
    avs_address    = byte_addr(word);
    avs_burstcount = BCW'(n);
    avs_read       = 1'b1;
    wait_accept(t);
    avs_read = 1'b0;
    for (int k = 0; k < nn; k++) begin
      b.c = t + k + RL;
      b.d = model_mem[(word + k) % DEPTH];
      exp_q.push_back(b);
    end
  endtask

  task automatic wr_burst(input int word, input int n, input int gap_after, input int gap_len,
                          input bit read_in_gap, output int last);
    int nn;
    int t;
    nn             = (n == 0) ? 1 : n;
    avs_address    = byte_addr(word);
    avs_burstcount = BCW'(n);
    for (int k = 0; k < nn; k++) begin
      avs_write      = 1'b1;
      avs_writedata  = wdata[k];
      avs_byteenable = wbe[k];
      if (k == 0) begin
        wait_accept(t);
      end else begin
        #1;
        total++;
        if (avs_waitrequest !== 1'b0)
          $display("[TB] FAIL wr_beat%0d_wait: waitrequest=%b required 0", k, avs_waitrequest);
        else passed++;
        t = cyc;
        @(posedge clock);
        #1;
      end
      model_write(word + k, wdata[k], wbe[k]);
      avs_write = 1'b0;
      if (k == gap_after) begin
        repeat (gap_len) begin
          avs_read = read_in_gap;
          tick();
        end
      end
      avs_read = 1'b0;
    end
    last = t;
    exp_ack.push_back(last + 1);
  endtask

  task automatic test_reset();
    resetn         = 1'b0;
    avs_read       = 1'b1;
    avs_burstcount = BCW'(1);
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if ({avs_waitrequest, avs_readdatavalid, avs_writeack, o_err} !== 4'b1000)
        $display("[TB] FAIL reset_outputs: wr/rdv/ack/err=%b required 1000",
                 {avs_waitrequest, avs_readdatavalid, avs_writeack, o_err});
      else passed++;
    end
    resetn   = 1'b1;
    avs_read = 1'b0;
    tick();
    total++;
    if (avs_waitrequest !== 1'b0 || avs_readdata !== '0)
      $display("[TB] FAIL reset_release: waitrequest=%b readdata=%h required 0 and 0", avs_waitrequest, avs_readdata);
    else passed++;
    avs_enable = 1'b0;
    #1;
    total++;
    if (avs_waitrequest !== 1'b1) $display("[TB] FAIL enable_low: waitrequest=%b required 1", avs_waitrequest);
    else passed++;
    avs_enable = 1'b1;
    tick();
    clear_queues();
  endtask

  task automatic test_write_read_burst();
    int  last, t;
    bit  ok;
    for (int k = 0; k < 4; k++) begin
      wdata[k] = MWIDTH'(8'h11 * (k + 1));
      wbe[k]   = '1;
    end
    wr_burst(2, 4, 0, 2, 1'b0, last);
    rd_burst(2, 4, t);
    for (int k = 1; k < 4; k++) begin
      total++;
      if (avs_waitrequest !== 1'b1) $display("[TB] FAIL rd_wait_cycle%0d: waitrequest=%b required 1", k, avs_waitrequest);
      else passed++;
      tick();
    end
    total++;
    if (avs_waitrequest !== 1'b0) $display("[TB] FAIL rd_wait_release: waitrequest=%b required 0", avs_waitrequest);
    else passed++;
    repeat (RL + 2) tick();
    total++;
    if (got_q.size() != exp_q.size()) $display("[TB] FAIL wrrd_count: got %0d beats required %0d", got_q.size(), exp_q.size());
    else passed++;
    foreach (exp_q[i]) if (i < got_q.size()) begin
      total++;
      if (got_q[i].c !== exp_q[i].c || got_q[i].d !== MWIDTH'(8'h11 * (i + 1)))
        $display("[TB] FAIL wrrd_beat%0d: cycle %0d data %h required cycle %0d data %h",
                 i, got_q[i].c, got_q[i].d, exp_q[i].c, MWIDTH'(8'h11 * (i + 1)));
      else passed++;
    end
    ok = (ack_q.size() == exp_ack.size());
    foreach (exp_ack[i]) if (ok && ack_q[i] != exp_ack[i]) ok = 1'b0;
    total++;
    if (!ok) $display("[TB] FAIL wrrd_ack: %0d acks first at %0d, required 1 at %0d",
                      ack_q.size(), (ack_q.size() > 0) ? ack_q[0] : -1, exp_ack[0]);
    else passed++;
    total++;
    if (avs_readdata !== MWIDTH'(8'h44) || avs_readdatavalid !== 1'b0)
      $display("[TB] FAIL readdata_hold: data %h valid %b required %h valid 0", avs_readdata, avs_readdatavalid, MWIDTH'(8'h44));
    else passed++;
    clear_queues();
  endtask

  task automatic test_byteenable();
    int last, t;
    wdata[0] = '1;
    wbe[0]   = '1;
    wr_burst(3, 1, -1, 0, 1'b0, last);
    wdata[0] = '0;
    wbe[0]   = NB'(1);
    wr_burst(3, 1, -1, 0, 1'b0, last);
    rd_burst(3, 1, t);
    repeat (RL + 2) tick();
    total++;
    if (got_q.size() != 1 || got_q[0].d !== {{(MWIDTH-8){1'b1}}, 8'h00} || got_q[0].c != exp_q[0].c)
      $display("[TB] FAIL byteenable: %0d beats data %h required 1 beat data %h at %0d", got_q.size(),
               (got_q.size() > 0) ? got_q[0].d : '0, {{(MWIDTH-8){1'b1}}, 8'h00}, exp_q[0].c);
    else passed++;
    total++;
    if (ack_q.size() != 2 || ack_q[0] != exp_ack[0] || ack_q[1] != exp_ack[1])
      $display("[TB] FAIL byteenable_ack: got %0d acks required 2", ack_q.size());
    else passed++;
    clear_queues();
  endtask

  task automatic test_wrap();
    int last, t;
    for (int k = 0; k < 4; k++) begin
      wdata[k] = MWIDTH'(k + 1);
      wbe[k]   = '1;
    end
    wr_burst(DEPTH - 2, 4, -1, 0, 1'b0, last);
    rd_burst(DEPTH - 2, 4, t);
    repeat (RL + 5) tick();
    total++;
    if (got_q.size() != 4) $display("[TB] FAIL wrap_count: got %0d beats required 4", got_q.size());
    else passed++;
    foreach (exp_q[i]) if (i < got_q.size()) begin
      total++;
      if (got_q[i].c !== exp_q[i].c || got_q[i].d !== MWIDTH'(i + 1))
        $display("[TB] FAIL wrap_beat%0d: cycle %0d data %h required cycle %0d data %h",
                 i, got_q[i].c, got_q[i].d, exp_q[i].c, MWIDTH'(i + 1));
      else passed++;
    end
    clear_queues();
  endtask

  task automatic test_back_to_back();
    int last, t1, t2;
    for (int k = 0; k < 3; k++) begin
      wdata[k] = rand_word();
      wbe[k]   = '1;
    end
    wr_burst(10, 3, -1, 0, 1'b0, last);
    rd_burst(0, 2, t1);
    rd_burst(10, 3, t2);
    total++;
    if (t2 != t1 + 2) $display("[TB] FAIL b2b_accept: second accept at %0d required %0d", t2, t1 + 2);
    else passed++;
    repeat (RL + 5) tick();
    total++;
    if (got_q.size() != 5) $display("[TB] FAIL b2b_count: got %0d beats required 5", got_q.size());
    else passed++;
    foreach (exp_q[i]) if (i < got_q.size()) begin
      total++;
      if (got_q[i].c !== t1 + RL + i || got_q[i].d !== exp_q[i].d)
        $display("[TB] FAIL b2b_beat%0d: cycle %0d data %h required cycle %0d data %h",
                 i, got_q[i].c, got_q[i].d, t1 + RL + i, exp_q[i].d);
      else passed++;
    end
    total++;
    if (o_err !== 1'b0) $display("[TB] FAIL b2b_err: o_err=%b required 0", o_err);
    else passed++;
    clear_queues();
  endtask

  task automatic test_read_after_write();
    int last, t;
    wdata[0] = rand_word();
    wbe[0]   = '1;
    wr_burst(50, 1, -1, 0, 1'b0, last);
    rd_burst(50, 1, t);
    repeat (RL + 2) tick();
    total++;
    if (t != last + 1 || got_q.size() != 1 || got_q[0].d !== wdata[0] || got_q[0].c != t + RL)
      $display("[TB] FAIL raw: accept %0d beats %0d data %h required accept %0d 1 beat data %h",
               t, got_q.size(), (got_q.size() > 0) ? got_q[0].d : '0, last + 1, wdata[0]);
    else passed++;
    clear_queues();
  endtask

  task automatic test_random_bursts();
    int  last, t, word, n;
    bit  ok;
    for (int it = 0; it < 6; it++) begin
      word = $urandom_range(0, DEPTH - 1);
      n    = $urandom_range(1, 16);
      for (int k = 0; k < 16; k++) begin
        wdata[k] = rand_word();
        wbe[k]   = '1;
      end
      wr_burst(word, n, $urandom_range(0, n - 1), $urandom_range(0, 2), 1'b0, last);
      for (int k = 0; k < 16; k++) begin
        wdata[k] = rand_word();
        wbe[k]   = NB'($urandom);
      end
      wr_burst(word, n, $urandom_range(0, n - 1), $urandom_range(0, 2), 1'b0, last);
      rd_burst(word, n, t);
      repeat (n + RL + 2) tick();
      ok = (got_q.size() == exp_q.size());
      foreach (exp_q[i]) if (ok && (got_q[i].c !== exp_q[i].c || got_q[i].d !== exp_q[i].d)) ok = 1'b0;
      total++;
      if (!ok) $display("[TB] FAIL random_it%0d: word %0d n %0d got %0d beats required %0d, contents or timing differ",
                        it, word, n, got_q.size(), exp_q.size());
      else passed++;
      total++;
      if (ack_q.size() != 2 || ack_q[0] != exp_ack[0] || ack_q[1] != exp_ack[1])
        $display("[TB] FAIL random_ack%0d: got %0d acks required 2 at %0d,%0d", it, ack_q.size(), exp_ack[0], exp_ack[1]);
      else passed++;
      clear_queues();
    end
    total++;
    if (o_err !== 1'b0) $display("[TB] FAIL random_err: o_err=%b required 0", o_err);
    else passed++;
  endtask

  task automatic test_errors();
    int last, t;
    do_reset();
    wdata[0] = rand_word();
    wbe[0]   = '1;
    avs_read = 1'b1;
    wr_burst(20, 1, -1, 0, 1'b0, last);
    total++;
    if (o_err !== 1'b1) $display("[TB] FAIL err_rw: o_err=%b required 1", o_err);
    else passed++;
    rd_burst(20, 1, t);
    repeat (RL + 4) tick();
    total++;
    if (got_q.size() != 1 || got_q[0].d !== wdata[0] || ack_q.size() != 1 || ack_q[0] != exp_ack[0])
      $display("[TB] FAIL err_rw_write: %0d beats %0d acks data %h required 1 beat 1 ack data %h",
               got_q.size(), ack_q.size(), (got_q.size() > 0) ? got_q[0].d : '0, wdata[0]);
    else passed++;
    total++;
    if (o_err !== 1'b1) $display("[TB] FAIL err_sticky: o_err=%b required 1", o_err);
    else passed++;

    do_reset();
    total++;
    if (o_err !== 1'b0) $display("[TB] FAIL err_clear: o_err=%b required 0", o_err);
    else passed++;
    rd_burst(20, 0, t);
    total++;
    if (o_err !== 1'b1 || avs_waitrequest !== 1'b0)
      $display("[TB] FAIL err_bc0: o_err=%b waitrequest=%b required 1 and 0", o_err, avs_waitrequest);
    else passed++;
    repeat (RL + 4) tick();
    total++;
    if (got_q.size() != 1 || got_q[0].d !== exp_q[0].d || got_q[0].c != exp_q[0].c)
      $display("[TB] FAIL err_bc0_beats: got %0d beats required exactly 1", got_q.size());
    else passed++;

    do_reset();
    for (int k = 0; k < 3; k++) begin
      wdata[k] = rand_word();
      wbe[k]   = '1;
    end
    wr_burst(30, 3, 0, 1, 1'b1, last);
    total++;
    if (o_err !== 1'b1) $display("[TB] FAIL err_rd_in_wr: o_err=%b required 1", o_err);
    else passed++;
    rd_burst(30, 3, t);
    repeat (RL + 5) tick();
    total++;
    if (got_q.size() != 3 || got_q[0].d !== wdata[0] || got_q[1].d !== wdata[1] || got_q[2].d !== wdata[2]
        || got_q[0].c != exp_q[0].c || ack_q.size() != 1 || ack_q[0] != exp_ack[0])
      $display("[TB] FAIL err_rd_in_wr_data: %0d beats %0d acks required 3 beats of written data and 1 ack",
               got_q.size(), ack_q.size());
    else passed++;

    do_reset();
    rd_burst(0, 8, t);
    exp_q.delete();
    tick();
    tick();
    resetn = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    repeat (RL + 10) tick();
    total++;
    if (got_q.size() != 0 || ack_q.size() != 0 || o_err !== 1'b0 || avs_waitrequest !== 1'b0)
      $display("[TB] FAIL reset_mid_read: %0d beats %0d acks err=%b wait=%b required 0 0 0 0",
               got_q.size(), ack_q.size(), o_err, avs_waitrequest);
    else passed++;
    clear_queues();
  endtask

  initial begin
    test_reset();
    test_write_read_burst();
    test_byteenable();
    test_wrap();
    test_back_to_back();
    test_read_after_write();
    test_random_bursts();
    test_errors();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
